// File: rtl/lcd_timing.sv
// rtl/lcd_timing.sv - Game Boy LCD dot/line timing, PPU mode and LCD interrupt requests
module lcd_timing #(
  parameter int DOTS_PER_LINE   = 456,
  parameter int LINES_PER_FRAME = 154,
  parameter int VISIBLE_LINES   = 144,
  parameter int OAM_DOTS        = 80,
  parameter int XFER_DOTS       = 172
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dot_en,
  input  logic [7:0] lcdc,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_ie,
  output logic       lcd_on,
  output logic [8:0] lx,
  output logic [7:0] ly,
  output logic [1:0] mode,
  output logic       lyc_match,
  output logic       vblank_irq,
  output logic       stat_irq
);

  localparam logic [8:0] LX_LAST  = 9'(DOTS_PER_LINE - 1);
  localparam logic [7:0] LY_LAST  = 8'(LINES_PER_FRAME - 1);
  localparam logic [7:0] LY_VBL   = 8'(VISIBLE_LINES);
  localparam logic [7:0] LY_PRE   = 8'(VISIBLE_LINES - 1);
  localparam logic [8:0] OAM_END  = 9'(OAM_DOTS);
  localparam logic [8:0] XFER_END = 9'(OAM_DOTS + XFER_DOTS);

  typedef enum logic {ST_OFF, ST_RUN} state_t;

  state_t     state_q;
  logic [8:0] lx_q, lx_d;
  logic [7:0] ly_q, ly_d;
  logic [1:0] mode_q, mode_d;
  logic       vblank_q, vblank_d;
  logic       stat_irq_q, stat_prev_q;
  logic       stat_cond;
  logic       lcdc_unused;

  assign lcdc_unused = ^lcdc[6:0];

  // Mode is derived from the post-increment position so it moves with lx/ly.
  always_comb begin
    lx_d = lx_q + 9'd1;
    ly_d = ly_q;
    if (lx_q == LX_LAST) begin
      lx_d = '0;
      ly_d = (ly_q == LY_LAST) ? 8'd0 : ly_q + 8'd1;
    end
    if (ly_d >= LY_VBL)        mode_d = 2'd1;
    else if (lx_d < OAM_END)   mode_d = 2'd2;
    else if (lx_d < XFER_END)  mode_d = 2'd3;
    else                       mode_d = 2'd0;
    vblank_d = (lx_q == LX_LAST) && (ly_q == LY_PRE);
  end

  assign lcd_on    = (state_q == ST_RUN);
  assign lx        = lx_q;
  assign ly        = ly_q;
  assign mode      = mode_q;
  assign lyc_match = lcd_on & (ly_q == lyc);
  assign vblank_irq = vblank_q;
  assign stat_irq   = stat_irq_q;

  assign stat_cond = lcd_on & ((stat_ie[0] & (mode_q == 2'd0)) |
                               (stat_ie[1] & (mode_q == 2'd1)) |
                               (stat_ie[2] & (mode_q == 2'd2)) |
                               (stat_ie[3] & lyc_match));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      lx_q        <= '0;
      ly_q        <= '0;
      mode_q      <= 2'd0;
      vblank_q    <= 1'b0;
      stat_irq_q  <= 1'b0;
      stat_prev_q <= 1'b0;
    end else begin
      vblank_q <= 1'b0;
      if (state_q == ST_OFF) begin
        stat_prev_q <= 1'b0;
        stat_irq_q  <= 1'b0;
        // The enabling edge only starts the LCD; counting waits for a later strobe.
        if (lcdc[7]) begin
          state_q <= ST_RUN;
          mode_q  <= 2'd2;
        end
      end else if (!lcdc[7]) begin
        state_q     <= ST_OFF;
        lx_q        <= '0;
        ly_q        <= '0;
        mode_q      <= 2'd0;
        stat_prev_q <= 1'b0;
        stat_irq_q  <= 1'b0;
      end else begin
        stat_prev_q <= stat_cond;
        stat_irq_q  <= stat_cond & ~stat_prev_q;
        if (dot_en) begin
          lx_q     <= lx_d;
          ly_q     <= ly_d;
          mode_q   <= mode_d;
          vblank_q <= vblank_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_timing.sv
// tb/tb_lcd_timing.sv - self-checking bench for lcd_timing with an IRQ position scoreboard
module tb_lcd_timing;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dot_en;
  logic [7:0] lcdc;
  logic [7:0] lyc;
  logic [3:0] stat_ie;
  logic       lcd_on;
  logic [8:0] lx;
  logic [7:0] ly;
  logic [1:0] mode;
  logic       lyc_match;
  logic       vblank_irq;
  logic       stat_irq;

  int checks = 0;
  int errors = 0;

  logic [8:0] e_lx;
  logic [7:0] e_ly;
  int stat_q[$];
  int vbl_q[$];
  int stat_exp;
  int vbl_exp;

  always #5 clk = ~clk;

  lcd_timing dut (
    .clk(clk), .rst_n(rst_n), .dot_en(dot_en), .lcdc(lcdc), .lyc(lyc),
    .stat_ie(stat_ie), .lcd_on(lcd_on), .lx(lx), .ly(ly), .mode(mode),
    .lyc_match(lyc_match), .vblank_irq(vblank_irq), .stat_irq(stat_irq)
  );

  // Scoreboard: every observed pulse must match the next expected {ly, lx} position.
  always @(negedge clk) begin
    if (stat_irq === 1'b1) begin
      checks++;
      if (stat_q.size() == 0) begin
        errors++;
        $display("FAIL stat_irq_unexpected got pulse at ly=%0d lx=%0d want none", ly, lx);
      end else begin
        stat_exp = stat_q.pop_front();
        if ({23'd0, ly, lx} !== stat_exp) begin
          errors++;
          $display("FAIL stat_irq_pos got ly=%0d lx=%0d want ly=%0d lx=%0d",
                   ly, lx, stat_exp / 512, stat_exp % 512);
        end
      end
    end
    if (vblank_irq === 1'b1) begin
      checks++;
      if (vbl_q.size() == 0) begin
        errors++;
        $display("FAIL vblank_irq_unexpected got pulse at ly=%0d lx=%0d want none", ly, lx);
      end else begin
        vbl_exp = vbl_q.pop_front();
        if ({23'd0, ly, lx} !== vbl_exp) begin
          errors++;
          $display("FAIL vblank_irq_pos got ly=%0d lx=%0d want ly=%0d lx=%0d",
                   ly, lx, vbl_exp / 512, vbl_exp % 512);
        end
      end
    end
  end

  function automatic logic [1:0] exp_mode(input logic [7:0] l, input logic [8:0] x);
    if (l >= 8'd144) return 2'd1;
    if (x < 9'd80)   return 2'd2;
    if (x < 9'd252)  return 2'd3;
    return 2'd0;
  endfunction

  // One counting edge with dot_en high; the expected position moves with it.
  task automatic step();
    @(negedge clk);
    if (e_lx == 9'd455) begin
      e_lx = 9'd0;
      e_ly = (e_ly == 8'd153) ? 8'd0 : e_ly + 8'd1;
    end else begin
      e_lx = e_lx + 9'd1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lcdc = 8'h00; dot_en = 1'b1; lyc = 8'd0; stat_ie = 4'hF;
    repeat (2) @(negedge clk);
    checks++;
    if ({lcd_on, lx, ly, mode, vblank_irq, stat_irq, lyc_match} !== 23'd0) begin
      errors++;
      $display("FAIL reset_state got on=%0b lx=%0d ly=%0d mode=%0d vbl=%0b stat=%0b match=%0b want all 0",
               lcd_on, lx, ly, mode, vblank_irq, stat_irq, lyc_match);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({lcd_on, lx, ly, mode} !== 20'd0) begin
      errors++;
      $display("FAIL off_hold got on=%0b lx=%0d ly=%0d mode=%0d want 0 0 0 0", lcd_on, lx, ly, mode);
    end
  endtask

  task automatic test_enable();
    stat_ie = 4'b0011; lyc = 8'd0; lcdc = 8'h91;
    @(negedge clk);
    e_lx = 9'd0; e_ly = 8'd0;
    checks++;
    if ({lcd_on, mode, lx, ly} !== {1'b1, 2'd2, 9'd0, 8'd0}) begin
      errors++;
      $display("FAIL enable got on=%0b mode=%0d lx=%0d ly=%0d want 1 2 0 0", lcd_on, mode, lx, ly);
    end
    checks++;
    if (lyc_match !== 1'b1) begin
      errors++;
      $display("FAIL lyc_match_ly0 got %0b want 1", lyc_match);
    end
    lyc = 8'd10;
    #1;
    checks++;
    if (lyc_match !== 1'b0) begin
      errors++;
      $display("FAIL lyc_match_comb got %0b want 0", lyc_match);
    end
  endtask

  task automatic test_dot_gate();
    dot_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({lx, ly, mode} !== {9'd0, 8'd0, 2'd2}) begin
      errors++;
      $display("FAIL dot_gate got lx=%0d ly=%0d mode=%0d want 0 0 2", lx, ly, mode);
    end
    dot_en = 1'b1;
  endtask

  task automatic test_line0_modes();
    stat_q.push_back(0 * 512 + 253);
    for (int s = 1; s <= 456; s++) begin
      step();
      checks++;
      if ({ly, lx, mode} !== {e_ly, e_lx, exp_mode(e_ly, e_lx)}) begin
        errors++;
        $display("FAIL line0_pos got ly=%0d lx=%0d mode=%0d want ly=%0d lx=%0d mode=%0d",
                 ly, lx, mode, e_ly, e_lx, exp_mode(e_ly, e_lx));
      end
    end
    checks++;
    if ({ly, lx, mode} !== {8'd1, 9'd0, 2'd2}) begin
      errors++;
      $display("FAIL line1_start got ly=%0d lx=%0d mode=%0d want 1 0 2", ly, lx, mode);
    end
  endtask

  task automatic test_frame();
    for (int l = 1; l < 144; l++) stat_q.push_back(l * 512 + 253);
    vbl_q.push_back(144 * 512);
    for (int s = 457; s <= 70224; s++) begin
      step();
      checks++;
      if ({ly, lx, mode} !== {e_ly, e_lx, exp_mode(e_ly, e_lx)}) begin
        errors++;
        $display("FAIL frame_pos got ly=%0d lx=%0d mode=%0d want ly=%0d lx=%0d mode=%0d",
                 ly, lx, mode, e_ly, e_lx, exp_mode(e_ly, e_lx));
      end
      checks++;
      if (lyc_match !== (e_ly == lyc)) begin
        errors++;
        $display("FAIL frame_lyc_match got %0b at ly=%0d want %0b", lyc_match, e_ly, e_ly == lyc);
      end
      if (s == 65664) begin
        checks++;
        if ({ly, mode, vblank_irq} !== {8'd144, 2'd1, 1'b1}) begin
          errors++;
          $display("FAIL vblank_entry got ly=%0d mode=%0d vbl=%0b want 144 1 1", ly, mode, vblank_irq);
        end
      end
      if (s == 65665) begin
        checks++;
        if (vblank_irq !== 1'b0) begin
          errors++;
          $display("FAIL vblank_width got %0b want 0", vblank_irq);
        end
      end
    end
    checks++;
    if ({ly, lx, mode} !== {8'd0, 9'd0, 2'd2}) begin
      errors++;
      $display("FAIL frame_wrap got ly=%0d lx=%0d mode=%0d want 0 0 2", ly, lx, mode);
    end
    checks++;
    if (stat_q.size() != 0 || vbl_q.size() != 0) begin
      errors++;
      $display("FAIL frame_missing got stat_left=%0d vbl_left=%0d want 0 0", stat_q.size(), vbl_q.size());
    end
  endtask

  task automatic test_lyc();
    stat_ie = 4'b1000; lyc = 8'd10;
    stat_q.push_back(10 * 512 + 1);
    for (int s = 1; s <= 50 * 456 + 300; s++) begin
      if (e_ly == 8'd11 && e_lx == 9'd0)   lyc = 8'd200;
      if (e_ly == 8'd30 && e_lx == 9'd200) begin
        lyc = 8'd30;
        stat_q.push_back(30 * 512 + 201);
      end
      if (e_ly == 8'd30 && e_lx == 9'd205) lyc = 8'd200;
      step();
      checks++;
      if (lyc_match !== (e_ly == lyc)) begin
        errors++;
        $display("FAIL lyc_match got %0b at ly=%0d lyc=%0d want %0b", lyc_match, e_ly, lyc, e_ly == lyc);
      end
    end
    checks++;
    if ({ly, lx} !== {8'd50, 9'd300} || stat_q.size() != 0) begin
      errors++;
      $display("FAIL lyc_end got ly=%0d lx=%0d stat_left=%0d want 50 300 0", ly, lx, stat_q.size());
    end
  endtask

  task automatic test_lcd_off();
    lcdc = 8'h11; stat_ie = 4'hF; lyc = 8'd0;
    @(negedge clk);
    checks++;
    if ({lcd_on, lx, ly, mode, lyc_match} !== 21'd0) begin
      errors++;
      $display("FAIL lcd_off got on=%0b lx=%0d ly=%0d mode=%0d match=%0b want all 0",
               lcd_on, lx, ly, mode, lyc_match);
    end
    for (int s = 0; s < 1000; s++) begin
      @(negedge clk);
      checks++;
      if ({lcd_on, lx, ly, mode, lyc_match} !== 21'd0) begin
        errors++;
        $display("FAIL off_hold got on=%0b lx=%0d ly=%0d mode=%0d match=%0b want all 0",
                 lcd_on, lx, ly, mode, lyc_match);
      end
    end
  endtask

  task automatic test_lcd_on();
    lcdc = 8'h91;
    @(negedge clk);
    e_lx = 9'd0; e_ly = 8'd0;
    checks++;
    if ({lcd_on, mode, lx, ly} !== {1'b1, 2'd2, 9'd0, 8'd0}) begin
      errors++;
      $display("FAIL reenable got on=%0b mode=%0d lx=%0d ly=%0d want 1 2 0 0", lcd_on, mode, lx, ly);
    end
    stat_q.push_back(0 * 512 + 1);
    for (int s = 1; s <= 100; s++) begin
      step();
      checks++;
      if ({ly, lx, mode} !== {e_ly, e_lx, exp_mode(e_ly, e_lx)}) begin
        errors++;
        $display("FAIL resume_pos got ly=%0d lx=%0d mode=%0d want ly=%0d lx=%0d mode=%0d",
                 ly, lx, mode, e_ly, e_lx, exp_mode(e_ly, e_lx));
      end
    end
    checks++;
    if (stat_q.size() != 0) begin
      errors++;
      $display("FAIL resume_stat got stat_left=%0d want 0", stat_q.size());
    end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({lcd_on, lx, ly, mode, vblank_irq, stat_irq, lyc_match} !== 23'd0) begin
      errors++;
      $display("FAIL async_reset got on=%0b lx=%0d ly=%0d mode=%0d vbl=%0b stat=%0b match=%0b want all 0",
               lcd_on, lx, ly, mode, vblank_irq, stat_irq, lyc_match);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({lcd_on, mode, lx, ly} !== {1'b1, 2'd2, 9'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_release got on=%0b mode=%0d lx=%0d ly=%0d want 1 2 0 0", lcd_on, mode, lx, ly);
    end
    e_lx = 9'd0; e_ly = 8'd0;
    stat_q.push_back(0 * 512 + 1);
    repeat (3) step();
    checks++;
    if (stat_q.size() != 0 || lx !== 9'd3) begin
      errors++;
      $display("FAIL reset_resume got lx=%0d stat_left=%0d want 3 0", lx, stat_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_enable();
    test_dot_gate();
    test_line0_modes();
    test_frame();
    test_lyc();
    test_lcd_off();
    test_lcd_on();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
